warp_issue_sched: RTL

//  Per-core warp scheduler: owns active/stalled warp state, per-warp thread masks and PCs.

---
 rtl/warp_sched_pkg.sv | 16 +
 rtl/warp_rr_arbiter.sv | 45 ++++
 rtl/warp_issue_sched.sv | 131 +++++++++++++
 3 files changed

// File: rtl/warp_sched_pkg.sv
// Shared widths and types for the per-core warp issue scheduler.
package warp_sched_pkg;
    localparam int NUM_WARPS   = 4;
    localparam int NUM_THREADS = 4;
    localparam int PC_BITS     = 30;
    localparam int NW_WIDTH    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

    typedef logic [NW_WIDTH-1:0]    wid_t;
    typedef logic [NUM_THREADS-1:0] tmask_t;
    typedef logic [PC_BITS-1:0]     pc_t;
    typedef logic [NUM_WARPS-1:0]   wmask_t;

    function automatic wid_t wid_inc(input wid_t w);
        return (int'(w) == NUM_WARPS - 1) ? '0 : wid_t'(w + 1'b1);
    endfunction
endpackage

// File: rtl/warp_rr_arbiter.sv
// Round-robin picker over warp requests; the pointer only moves when the grant is consumed.
module warp_rr_arbiter
    import warp_sched_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  wmask_t req,
    input  logic   advance,
    output logic   gnt_valid,
    output wmask_t gnt_oh,
    output wid_t   gnt_idx
);

    wid_t ptr_q, ptr_d;
    wid_t cand [NUM_WARPS];

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        gnt_oh    = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            cand[i] = wid_t'((int'(ptr_q) + i) % NUM_WARPS);
        end
        // Walk from the farthest candidate back so the one nearest the pointer wins.
        for (int i = NUM_WARPS - 1; i >= 0; i--) begin
            if (req[cand[i]]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand[i];
            end
        end
        if (gnt_valid) begin
            gnt_oh[gnt_idx] = 1'b1;
        end
        ptr_d = (advance && gnt_valid) ? wid_inc(gnt_idx) : ptr_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/warp_issue_sched.sv
// Per-core warp scheduler: tracks active/stalled warps, masks and PCs, and offers one warp per cycle to fetch.
module warp_issue_sched
    import warp_sched_pkg::*;
#(
    parameter pc_t STARTUP_PC = '0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wspawn_valid,
    input  wmask_t                      wspawn_mask,
    input  pc_t                         wspawn_pc,
    input  logic                        tmc_valid,
    input  wid_t                        tmc_wid,
    input  tmask_t                      tmc_mask,
    input  logic                        br_valid,
    input  wid_t                        br_wid,
    input  logic                        br_taken,
    input  pc_t                         br_pc,
    input  logic                        unlock_valid,
    input  wid_t                        unlock_wid,
    output logic                        sched_valid,
    input  logic                        sched_ready,
    output wid_t                        sched_wid,
    output pc_t                         sched_pc,
    output tmask_t                      sched_tmask,
    output wmask_t                      active_warps,
    output wmask_t                      stalled_warps,
    output tmask_t [NUM_WARPS-1:0]      thread_masks,
    output pc_t    [NUM_WARPS-1:0]      warp_pcs,
    output logic                        busy
);

    wmask_t                 active_q, active_d;
    wmask_t                 stalled_q, stalled_d;
    tmask_t [NUM_WARPS-1:0] tmask_q, tmask_d;
    pc_t    [NUM_WARPS-1:0] pc_q, pc_d;

    logic   gnt_valid;
    wmask_t gnt_oh;
    wid_t   gnt_idx;
    logic   fire;

    warp_rr_arbiter u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (active_q & ~stalled_q),
        .advance   (fire),
        .gnt_valid (gnt_valid),
        .gnt_oh    (gnt_oh),
        .gnt_idx   (gnt_idx)
    );

    assign sched_valid = gnt_valid & ~reset;
    assign fire        = sched_valid & sched_ready;
    assign sched_wid   = gnt_idx;
    assign sched_pc    = pc_q[gnt_idx];
    assign sched_tmask = tmask_q[gnt_idx];

    assign active_warps  = active_q;
    assign stalled_warps = stalled_q;
    assign thread_masks  = tmask_q;
    assign warp_pcs      = pc_q;
    assign busy          = |active_q;

    always_comb begin
        active_d  = active_q;
        stalled_d = stalled_q | (fire ? gnt_oh : '0);
        tmask_d   = tmask_q;
        pc_d      = pc_q;

        if (fire) begin
            pc_d[gnt_idx] = pc_q[gnt_idx] + 1'b1;
        end

        // Release order matters only for the same warp: tmc/br land after unlock.
        if (unlock_valid && active_q[unlock_wid]) begin
            stalled_d[unlock_wid] = 1'b0;
        end
        if (tmc_valid && active_q[tmc_wid]) begin
            stalled_d[tmc_wid] = 1'b0;
            tmask_d[tmc_wid]   = tmc_mask;
            if (tmc_mask == '0) begin
                active_d[tmc_wid] = 1'b0;
            end
        end
        if (br_valid && active_q[br_wid]) begin
            stalled_d[br_wid] = 1'b0;
            if (br_taken) begin
                pc_d[br_wid] = br_pc;
            end
        end

        for (int i = 0; i < NUM_WARPS; i++) begin
            if (wspawn_valid && wspawn_mask[i] && !active_q[i]) begin
                active_d[i]  = 1'b1;
                stalled_d[i] = 1'b0;
                pc_d[i]      = wspawn_pc;
                tmask_d[i]   = tmask_t'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q   <= wmask_t'(1);
            stalled_q  <= '0;
            tmask_q    <= '0;
            tmask_q[0] <= tmask_t'(1);
            pc_q       <= '0;
            pc_q[0]    <= STARTUP_PC;
        end else begin
            active_q  <= active_d;
            stalled_q <= stalled_d;
            tmask_q   <= tmask_d;
            pc_q      <= pc_d;
        end
    end

    // Upstream protocol checks: no updates to dead warps or to the warp being issued.
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(tmc_valid && !active_q[tmc_wid]));
            assert (!(br_valid && !active_q[br_wid]));
            assert (!(unlock_valid && !active_q[unlock_wid]));
            assert (!(fire && tmc_valid && tmc_wid == gnt_idx));
            assert (!(fire && br_valid && br_wid == gnt_idx));
            assert (!(fire && unlock_valid && unlock_wid == gnt_idx));
        end
    end

endmodule
